smith_waterman_pe: RTL and testbench
====================================

Name: smith_waterman_pe

Overview:
- One processing element (PE) of a linear systolic array that computes Smith-Waterman local alignment with an affine gap penalty.
- Each PE holds one short-read (query) base, S. Reference bases, T, stream through the array one per clock.
- Each cycle the PE computes one cell of the DP matrix (scores V, E, F) and forwards V, F, T and the control flags to the next PE.

Parameters:
- WIDTH, 10, bit width of all scores (V, E, F, init values); two's-complement signed.
- MATCH, 10, score added when S == T.
- MISMATCH, -2, score added when S != T.
- GAP_OPEN, -2, added to a V value when a gap is opened or continued from V.
- GAP_EXTEND, -1, added to an existing E or F value to extend a gap.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  when 1, every register holds its value.
- V_in  in  WIDTH  V score from the previous PE (cell above).
- F_in  in  WIDTH  F score from the previous PE.
- T_in  in  2  reference base.
- S_in  in  2  query base to store.
- store_S_in  in  1  load S_in into the S register.
- init_in  in  1  0 = initialise the row state; 1 = compute a cell.
- init_V  in  WIDTH  initial left V value.
- init_E  in  WIDTH  initial left E value.
- V_out  out  WIDTH  registered cell score V.
- E_out  out  WIDTH  registered horizontal gap score E.
- F_out  out  WIDTH  registered vertical gap score F.
- S_out  out  2  the stored S register.
- T_out  out  2  T_in delayed by 1 cycle.
- store_S_out  out  1  store_S_in delayed by 1 cycle.
- init_out  out  1  init_in delayed by 1 cycle.

Behaviour:
- Reset (rst = 1 at a clock edge; takes priority over stall): every register and output = 0.
- Stall (stall = 1, rst = 0): every register holds.
- Otherwise, every edge:
  - T_out <= T_in; init_out <= init_in; store_S_out <= store_S_in.
  - Vdiag <= V_in (internal register; Vdiag holds the previous V_in).
- S register: S <= S_in when store_S_in = 1, else hold. A cell computed in the same cycle as a store uses the old S value.
- Score terms, all signed:
  - sub = (S == T_in) ? MATCH : MISMATCH.
  - E_new = max(V_out + GAP_OPEN, E_out + GAP_EXTEND).
  - F_new = max(V_in + GAP_OPEN, F_in + GAP_EXTEND).
  - V_new = max(0, Vdiag + sub, E_new, F_new).
- Register updates:
  - F_out <= F_new on every non-stalled edge, regardless of init_in.
  - init_in = 1: V_out <= V_new, E_out <= E_new.
  - init_in = 0: V_out <= init_V, E_out <= init_E (no cell computed).
- Latency: 1 cycle from inputs to V_out, E_out, F_out, T_out and the flags.
- Arithmetic: intermediates are WIDTH+1 bits.
  - V saturates at 2^(WIDTH-1)-1.
  - E and F saturate at -2^(WIDTH-1).
  - No wrap-around.
- V_out is never negative.

Optional Feature:
- Macro SW_PE_MAX_TRACK_EN.
- When defined: adds output max_out (WIDTH bits), the running maximum of V_out since the last init cycle.
  - Reset value 0.
  - An init cycle (init_in = 0) loads 0.
  - A compute cycle loads max(max_out, V_new).
  - Holds during stall.
- When undefined: no max_out port and no associated logic.

Test Plan:
- Parameters (10, 10, -2, -2, -1); init_V = init_E = 0.
- Run each reference stream for 8 cycles with init_in = 1 after a store cycle that has init_in = 0.
- S = A(00), V_in = 0, F_in = 0, reference 00,01,00,10,00,01,11,00 -> V_out 10,8,10,8,10,8,7,10; F_out = -1 every cycle; T_out echoes each base; init_out = 1.
- Same stream, S = C(01) -> V_out 0,10,8,7,6,10,8,7; F_out = -1.
- S = T(11), V_in = 10, F_in = -4 -> V_out 8,8,8,8,8,8,20,18; F_out = 8.
- Store cycle -> next edge: store_S_out = 1, S_out = new base, init_out = 0. Following cycles: store_S_out = 0.
- Assert stall mid-stream for 3 cycles -> all outputs frozen; sequence resumes exactly afterwards. Assert rst mid-stream -> all outputs 0 the next edge.
- With the macro defined, S = A stream -> max_out 10 after the first cell; an init cycle then sets max_out = 0.

Source files
------------

// File: rtl/smith_waterman_pe_if.sv
// rtl/smith_waterman_pe_if.sv - systolic link bundle for one Smith-Waterman PE
//
// Carries every non-clock/reset signal of a PE.
//   master : the upstream side (previous PE or test driver), drives the *_in,
//            init_V/init_E and stall signals and observes the *_out signals.
//   slave  : the PE itself.
// Optional: SW_PE_MAX_TRACK_EN adds max_out (running maximum of V_out).
interface smith_waterman_pe_if #(
  parameter int WIDTH = 10
);
  logic                    stall;
  logic signed [WIDTH-1:0] V_in;
  logic signed [WIDTH-1:0] F_in;
  logic [1:0]              T_in;
  logic [1:0]              S_in;
  logic                    store_S_in;
  logic                    init_in;
  logic signed [WIDTH-1:0] init_V;
  logic signed [WIDTH-1:0] init_E;
  logic signed [WIDTH-1:0] V_out;
  logic signed [WIDTH-1:0] E_out;
  logic signed [WIDTH-1:0] F_out;
  logic [1:0]              S_out;
  logic [1:0]              T_out;
  logic                    store_S_out;
  logic                    init_out;
`ifdef SW_PE_MAX_TRACK_EN
  logic signed [WIDTH-1:0] max_out;

  modport master (
    output stall, V_in, F_in, T_in, S_in, store_S_in, init_in, init_V, init_E,
    input  V_out, E_out, F_out, S_out, T_out, store_S_out, init_out, max_out
  );
  modport slave (
    input  stall, V_in, F_in, T_in, S_in, store_S_in, init_in, init_V, init_E,
    output V_out, E_out, F_out, S_out, T_out, store_S_out, init_out, max_out
  );
`else
  modport master (
    output stall, V_in, F_in, T_in, S_in, store_S_in, init_in, init_V, init_E,
    input  V_out, E_out, F_out, S_out, T_out, store_S_out, init_out
  );
  modport slave (
    input  stall, V_in, F_in, T_in, S_in, store_S_in, init_in, init_V, init_E,
    output V_out, E_out, F_out, S_out, T_out, store_S_out, init_out
  );
`endif
endinterface

// File: rtl/smith_waterman_pe.sv
// rtl/smith_waterman_pe.sv - one affine-gap Smith-Waterman systolic processing element
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (beats stall)
//   bus  : smith_waterman_pe_if.slave
//          in : stall, V_in, F_in, T_in, S_in, store_S_in, init_in, init_V, init_E
//          out: V_out, E_out, F_out, S_out, T_out, store_S_out, init_out
//               (+ max_out when SW_PE_MAX_TRACK_EN is defined)
// All outputs are registered, one cycle after the inputs they depend on.
module smith_waterman_pe #(
  parameter int WIDTH      = 10,
  parameter int MATCH      = 10,
  parameter int MISMATCH   = -2,
  parameter int GAP_OPEN   = -2,
  parameter int GAP_EXTEND = -1
) (
  input  logic                 clk,
  input  logic                 rst,
  smith_waterman_pe_if.slave   bus
);

  // One extra bit of headroom so a single add never wraps before saturation.
  typedef logic signed [WIDTH:0]   wide_t;
  typedef logic signed [WIDTH-1:0] score_t;

  localparam wide_t MATCH_W    = (WIDTH+1)'(MATCH);
  localparam wide_t MISMATCH_W = (WIDTH+1)'(MISMATCH);
  localparam wide_t GAP_OPEN_W = (WIDTH+1)'(GAP_OPEN);
  localparam wide_t GAP_EXT_W  = (WIDTH+1)'(GAP_EXTEND);
  localparam wide_t MAX_W      = (WIDTH+1)'(2**(WIDTH-1) - 1);
  localparam wide_t MIN_W      = (WIDTH+1)'(-(2**(WIDTH-1)));

  function automatic wide_t ext(input score_t x);
    return $signed({x[WIDTH-1], x});
  endfunction

  function automatic wide_t max2(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic score_t sat(input wide_t x);
    wide_t y;
    y = x;
    if (x > MAX_W) y = MAX_W;
    if (x < MIN_W) y = MIN_W;
    return y[WIDTH-1:0];
  endfunction

  score_t     v_q, e_q, f_q, vdiag_q;
  logic [1:0] s_q, t_q;
  logic       store_q, init_q;

  wide_t  sub_w;
  score_t e_new, f_new, v_new;

  // The cell uses the S already held; a store in the same cycle lands afterwards.
  assign sub_w = (s_q == bus.T_in) ? MATCH_W : MISMATCH_W;
  assign e_new = sat(max2(ext(v_q) + GAP_OPEN_W, ext(e_q) + GAP_EXT_W));
  assign f_new = sat(max2(ext(bus.V_in) + GAP_OPEN_W, ext(bus.F_in) + GAP_EXT_W));
  // The zero floor keeps V non-negative, so only the upper bound can bite.
  assign v_new = sat(max2(max2('0, ext(vdiag_q) + sub_w),
                          max2(ext(e_new), ext(f_new))));

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      vdiag_q <= '0;
      s_q     <= '0;
      t_q     <= '0;
      store_q <= 1'b0;
      init_q  <= 1'b0;
    end else if (!bus.stall) begin
      t_q     <= bus.T_in;
      store_q <= bus.store_S_in;
      init_q  <= bus.init_in;
      vdiag_q <= bus.V_in;
      f_q     <= f_new;
      if (bus.store_S_in) s_q <= bus.S_in;
      if (bus.init_in) begin
        v_q <= v_new;
        e_q <= e_new;
      end else begin
        v_q <= bus.init_V;
        e_q <= bus.init_E;
      end
    end
  end

  assign bus.V_out       = v_q;
  assign bus.E_out       = e_q;
  assign bus.F_out       = f_q;
  assign bus.S_out       = s_q;
  assign bus.T_out       = t_q;
  assign bus.store_S_out = store_q;
  assign bus.init_out    = init_q;

`ifdef SW_PE_MAX_TRACK_EN
  score_t max_q;

  // Running best score of the current row; an init cycle starts a new row.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else if (!bus.stall) begin
      if (!bus.init_in)       max_q <= '0;
      else if (v_new > max_q) max_q <= v_new;
    end
  end

  assign bus.max_out = max_q;
`else
  // Running-maximum tracking not built.
`endif

endmodule

// File: tb/tb_smith_waterman_pe.sv
// tb/tb_smith_waterman_pe.sv - directed scoreboard bench for smith_waterman_pe
module tb_smith_waterman_pe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  smith_waterman_pe_if #(.WIDTH(10)) bus ();

  smith_waterman_pe #(
    .WIDTH(10), .MATCH(10), .MISMATCH(-2), .GAP_OPEN(-2), .GAP_EXTEND(-1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [31:0] v, e, f, mx;
    logic [1:0]         t, s;
    logic               init, store;
  } exp_t;

  exp_t exp_q[$];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state (value after the most recent edge).
  int         m_v = 0, m_e = 0, m_f = 0, m_vd = 0, m_mx = 0;
  logic [1:0] m_s = 2'd0, m_t = 2'd0;
  logic       m_init = 1'b0, m_store = 1'b0;

  function automatic int clamp(input int x);
    if (x > 511)  return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input logic [1:0] t, input int vin, input int fin, input logic [1:0] sin,
                       input logic store, input logic init, input logic stl, input logic r);
    int sub, en, fn, vn;
    if (r) begin
      m_v = 0; m_e = 0; m_f = 0; m_vd = 0; m_mx = 0;
      m_s = 2'd0; m_t = 2'd0; m_init = 1'b0; m_store = 1'b0;
    end else if (!stl) begin
      sub = (m_s == t) ? 10 : -2;
      en  = clamp(imax(m_v - 2, m_e - 1));
      fn  = clamp(imax(vin - 2, fin - 1));
      vn  = clamp(imax(imax(0, m_vd + sub), imax(en, fn)));
      if (init) begin
        m_v = vn; m_e = en; m_mx = imax(m_mx, vn);
      end else begin
        m_v = 0; m_e = 0; m_mx = 0;
      end
      m_f = fn; m_vd = vin;
      if (store) m_s = sin;
      m_t = t; m_init = init; m_store = store;
    end
  endtask

  task automatic step(input logic [1:0] t, input int vin, input int fin, input logic [1:0] sin,
                      input logic store, input logic init, input logic stl, input logic r);
    exp_t e;
    bus.T_in = t; bus.V_in = 10'(vin); bus.F_in = 10'(fin); bus.S_in = sin;
    bus.store_S_in = store; bus.init_in = init; bus.stall = stl; rst = r;
    model(t, vin, fin, sin, store, init, stl, r);
    e.v = m_v; e.e = m_e; e.f = m_f; e.mx = m_mx;
    e.t = m_t; e.s = m_s; e.init = m_init; e.store = m_store;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'sd0, 32'sd1);
    end else begin
      e = exp_q.pop_front();
      chk("V_out", $signed(bus.V_out), e.v);
      chk("E_out", $signed(bus.E_out), e.e);
      chk("F_out", $signed(bus.F_out), e.f);
      chk("T_out", {30'd0, bus.T_out}, {30'd0, e.t});
      chk("S_out", {30'd0, bus.S_out}, {30'd0, e.s});
      chk("init_out", {31'd0, bus.init_out}, {31'd0, e.init});
      chk("store_S_out", {31'd0, bus.store_S_out}, {31'd0, e.store});
`ifdef SW_PE_MAX_TRACK_EN
      chk("max_out", $signed(bus.max_out), e.mx);
`endif
    end
    @(negedge clk);
  endtask

  logic [1:0] refs [8];

  initial begin
    refs = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
    bus.stall = 1'b0; bus.V_in = '0; bus.F_in = '0; bus.T_in = '0; bus.S_in = '0;
    bus.store_S_in = 1'b0; bus.init_in = 1'b0; bus.init_V = '0; bus.init_E = '0;
    @(negedge clk);

    // Reset state.
    step(2'd0, 0, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'd0, 0, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // S = A: expect V 10,8,10,8,10,8,7,10 and F -1.
    step(2'd0, 0, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(refs[i], 0, 0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // S = C with a 3-cycle stall mid-stream; junk inputs during stall must be ignored.
    step(2'd0, 0, 0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4)
        for (int k = 0; k < 3; k++) step(2'd3, 77, 33, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      step(refs[i], 0, 0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // S = T, V_in = 10, F_in = -4: expect V 8,8,8,8,8,8,20,18 and F 8.
    step(2'd0, 10, -4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(refs[i], 10, -4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream, asserted together with stall.
    step(2'd0, 10, -4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(refs[0], 10, -4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(refs[1], 10, -4, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(refs[2], 10, -4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturation: V clamps at 511, F clamps at -512.
    step(2'd0, 511, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'd0, -512, -512, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'd0, 511, 0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'd0, 511, 511, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Init cycle restarts the row (and the running maximum).
    step(2'd0, 0, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'd0, 0, 0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
